// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier.
// One multiplier bit is retired per clock through a ripple chain of 1-bit
// Adder cells; the product is registered and a one-cycle done pulse follows.

// 1-bit full-adder cell used to build the partial-product ripple chain.
module Adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic [CW-1:0]        r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH:0]       w_carry;
    logic [2*WIDTH-1:0]   w_next_aq;

    // Add M only when the current multiplier lsb is set; otherwise A passes through.
    assign w_addend   = r_q[0] ? r_m : '0;
    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ripple
            Adder u_fa (
                .i_a    (r_a[gi]),
                .i_b    (w_addend[gi]),
                .i_cin  (w_carry[gi]),
                .o_sum  (w_sum[gi]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    // Shift {C,S,Q} right by one: the carry lands in the A msb so it is never lost,
    // and the retired multiplier lsb falls off the bottom.
    assign w_next_aq = {w_carry[WIDTH], w_sum, r_q[WIDTH-1:1]};

    // Control FSM with operand/accumulator datapath and registered outputs.
    // NOTE: every register here, datapath included, is cleared by reset so an
    // aborted operation leaves no stale partial product behind; all updates use
    // non-blocking assignments so each edge sees only the previous cycle's values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_a     <= '0;
                        r_count <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a     <= w_next_aq[2*WIDTH-1:WIDTH];
                    r_q     <= w_next_aq[WIDTH-1:0];
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_product <= w_next_aq;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: an 8-bit instance for the
// latency/reset/start-hold cases and a 4-bit instance for the exhaustive sweep.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start4;
    logic [3:0]  multiplicand4;
    logic [3:0]  multiplier4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shift_add_multiplier #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start4),
        .multiplicand (multiplicand4),
        .multiplier   (multiplier4),
        .busy         (busy4),
        .done         (done4),
        .product      (product4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance past the next rising edge; samples and drives happen 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one 8-bit operation from IDLE and check latency, busy window and result.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input string tag);
        int cyc;
        int busy_cyc;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        tick();                       // E0
        start        = 1'b0;
        multiplicand = ~m;            // must not affect the accepted operation
        multiplier   = ~q;
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_busy_cycles"}, busy_cyc, 8);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_at_done"}, busy, 0);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int done_seen;
        int first_edge, second_edge;
        logic [15:0] first_prod, second_prod;
        int cyc;

        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        start4 = 1'b0; multiplicand4 = '0; multiplier4 = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        repeat (2) tick();
        #2 rst = 1'b0;
        tick();

        // Basic, all-ones carry stress and zero operands.
        run_op(8'd13, 8'd11, 16'd143, "m13_q11");
        run_op(8'd255, 8'd255, 16'd65025, "m255_q255");
        run_op(8'd0, 8'd200, 16'd0, "m0_q200");
        run_op(8'd200, 8'd0, 16'd0, "m200_q0");
        run_op(8'd13, 8'd11, 16'd143, "m13_q11_again");

        // Asynchronous reset in the middle of RUN (cycle 4), between clock edges.
        multiplicand = 8'd99; multiplier = 8'd77; start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        repeat (3) tick();            // E1..E3
        check("pre_abort_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        #1 rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_op(8'd7, 8'd9, 16'd63, "after_abort_m7_q9");

        // start held high, operands changing every cycle.
        multiplicand = 8'd5; multiplier = 8'd6; start = 1'b1;
        tick();                       // E0 accepts 5*6
        done_seen = 0; first_edge = -1; second_edge = -1;
        first_prod = '0; second_prod = '0;
        for (int k = 1; k <= 19; k++) begin
            multiplicand = 8'(k * 17 + 3);   // at E10: 173
            multiplier   = 8'(k + 2);        // at E10: 12
            tick();
            if (done) begin
                done_seen++;
                if (first_edge < 0) begin
                    first_edge = k; first_prod = product;
                end else begin
                    second_edge = k; second_prod = product;
                end
            end
        end
        start = 1'b0;
        tick();                       // E20, stays IDLE
        check("hold_done_count", done_seen, 2);
        check("hold_first_edge", first_edge, 8);
        check("hold_first_product", first_prod, 30);
        check("hold_second_edge", second_edge, 18);
        check("hold_second_product", second_prod, 2076);
        check("hold_idle_after", busy, 0);
        check("hold_product_stable", product, 2076);

        // WIDTH=4: every operand pair, back-to-back.
        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                multiplicand4 = 4'(m);
                multiplier4   = 4'(q);
                start4        = 1'b1;
                tick();
                start4 = 1'b0;
                cyc = 0;
                while (!done4 && cyc < 10) begin
                    tick();
                    cyc++;
                end
                check($sformatf("w4_%0dx%0d", m, q), {cyc[7:0], product4}, {8'd4, 8'(m * q)});
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
